// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC(/EXEC2)/MEM/WB with a memory ready handshake.
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.
module multicycle_control #(
  parameter int OPW  = 3,
  parameter int FNW  = 4,
  parameter int CDW  = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mem_ready,
  input  logic [OPW-1:0]  opcode,
  input  logic [FNW-1:0]  func,
  output logic            ir_load,
  output logic            pc_write,
  output logic            mem_read_en,
  output logic            mem_write_en,
  output logic            reg_write_en,
  output logic            memToReg,
  output logic            branch_control,
  output logic [1:0]      alu_src,
  output logic [CDW-1:0]  code,
  output logic [5:0]      bcode,
  output logic            double,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic [CNTW-1:0] instr_count,
  output logic [CNTW-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [OPW-1:0] OP_ALU  = OPW'(0);
  localparam logic [OPW-1:0] OP_ALUI = OPW'(1);
  localparam logic [OPW-1:0] OP_LS   = OPW'(2);
  localparam logic [OPW-1:0] OP_BR3  = OPW'(3);
  localparam logic [OPW-1:0] OP_BR4  = OPW'(4);
  localparam logic [OPW-1:0] OP_BR5  = OPW'(5);
  localparam logic [OPW-1:0] OP_ILL  = OPW'(6);
  localparam logic [OPW-1:0] OP_HALT = OPW'(7);

  state_t         state, state_n;
  logic [OPW-1:0] op_q;
  logic [FNW-1:0] func_q;
  logic           illegal_q;
  logic           latch_ir;
  logic           set_illegal;

  logic [CDW-1:0] dec_code;
  logic [1:0]     dec_src;
  logic           dec_dbl;
  logic           op0_legal;
  logic           is_load;
  logic           is_store;

  assign op0_legal = (32'(func_q) <= 32'd11);
  assign is_load   = (op_q == OP_LS) && (func_q == FNW'(0));
  assign is_store  = (op_q == OP_LS) && (func_q == FNW'(1));

  // ALU decode of the latched instruction; only presented on the outputs during EXEC/EXEC2
  always_comb begin
    dec_code = '0;
    dec_src  = '0;
    dec_dbl  = 1'b0;
    case (op_q)
      OP_ALU: begin
        case (func_q)
          FNW'(0):  dec_code = CDW'(1);
          FNW'(1):  begin dec_code = CDW'(3); dec_dbl = 1'b1; end
          FNW'(2):  begin dec_code = CDW'(4); dec_dbl = 1'b1; end
          FNW'(3):  dec_code = CDW'(5);
          FNW'(4):  dec_code = CDW'(6);
          FNW'(5):  dec_code = CDW'(7);
          FNW'(6):  begin dec_code = CDW'(8); dec_src = 2'd1; end
          FNW'(7):  begin dec_code = CDW'(9); dec_src = 2'd1; end
          FNW'(8):  dec_code = CDW'(8);
          FNW'(9):  dec_code = CDW'(9);
          FNW'(10): begin dec_code = CDW'(10); dec_src = 2'd1; end
          FNW'(11): dec_code = CDW'(10);
          default:  ;
        endcase
      end
      OP_ALUI: begin
        dec_src = 2'd2;
        if (func_q == FNW'(0))      dec_code = CDW'(5);
        else if (func_q == FNW'(1)) dec_code = CDW'(1);
      end
      OP_LS: begin
        dec_src  = 2'd2;
        dec_code = CDW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n        = state;
    latch_ir       = 1'b0;
    set_illegal    = 1'b0;
    ir_load        = 1'b0;
    pc_write       = 1'b0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    reg_write_en   = 1'b0;
    memToReg       = 1'b0;
    branch_control = 1'b0;
    alu_src        = '0;
    code           = '0;
    double         = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = S_FETCH;
      S_FETCH: begin
        mem_read_en = 1'b1;
        if (mem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          latch_ir = 1'b1;
          state_n  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_q == OP_HALT) begin
          state_n = S_HALT;
        end else if (op_q == OP_ILL || (op_q == OP_ALU && !op0_legal)) begin
          state_n     = S_HALT;
          set_illegal = 1'b1;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        code    = dec_code;
        alu_src = dec_src;
        double  = dec_dbl;
        case (op_q)
          OP_ALU:         state_n = dec_dbl ? S_EXEC2 : S_WB;
          OP_ALUI:        state_n = S_WB;
          OP_LS:          state_n = S_MEM;
          OP_BR3, OP_BR5: begin branch_control = 1'b1; state_n = S_FETCH; end
          OP_BR4: begin
            branch_control = 1'b1;
            state_n = (func_q[1:0] == 2'b00) ? S_WB : S_FETCH;
          end
          default:        state_n = S_FETCH;
        endcase
      end
      S_EXEC2: begin
        code    = dec_code;
        alu_src = dec_src;
        double  = 1'b1;
        state_n = S_WB;
      end
      S_MEM: begin
        if (is_load) begin
          mem_read_en = 1'b1;
          if (mem_ready) state_n = S_WB;
        end else if (is_store) begin
          mem_write_en = 1'b1;
          if (mem_ready) state_n = S_FETCH;
        end else begin
          state_n = S_FETCH;
        end
      end
      S_WB: begin
        reg_write_en = 1'b1;
        memToReg     = is_load;
        state_n      = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      func_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_n;
      if (latch_ir) begin
        op_q   <= opcode;
        func_q <= func;
      end
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  assign bcode   = 6'({op_q, func_q[2:0]});
  assign busy    = (state != S_IDLE) && (state != S_HALT);
  assign halted  = (state == S_HALT);
  assign illegal = illegal_q;

`ifdef MC_PERF_CNT_EN
  logic            retire;
  logic [CNTW-1:0] instr_q;
  logic [CNTW-1:0] cycle_q;

  // Retirement is the transition out of an instruction's final phase
  assign retire = (state == S_WB) ||
                  (((state == S_MEM) || (state == S_EXEC)) && (state_n == S_FETCH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      cycle_q <= '0;
    end else begin
      if (busy)   cycle_q <= cycle_q + 1'b1;
      if (retire) instr_q <= instr_q + 1'b1;
    end
  end

  assign instr_count = instr_q;
  assign cycle_count = cycle_q;
`else
  assign instr_count = '0;
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level reference model, randomized
// programs and memory latency, monitor comparing per-instruction phase shape and strobes.
module tb_multicycle_control;
  localparam int OPW = 3, FNW = 4, CDW = 4, CNTW = 16;
`ifdef MC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, mem_ready;
  logic [OPW-1:0] opcode;
  logic [FNW-1:0] func;
  logic ir_load, pc_write, mem_read_en, mem_write_en, reg_write_en, memToReg, branch_control;
  logic [1:0] alu_src;
  logic [CDW-1:0] code;
  logic [5:0] bcode;
  logic double, busy, halted, illegal;
  logic [CNTW-1:0] instr_count, cycle_count;

  always #5 clk = ~clk;

  multicycle_control #(.OPW(OPW), .FNW(FNW), .CDW(CDW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready), .opcode(opcode), .func(func),
    .ir_load(ir_load), .pc_write(pc_write), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .reg_write_en(reg_write_en), .memToReg(memToReg), .branch_control(branch_control),
    .alu_src(alu_src), .code(code), .bcode(bcode), .double(double), .busy(busy), .halted(halted),
    .illegal(illegal), .instr_count(instr_count), .cycle_count(cycle_count)
  );

  typedef struct {
    int op, fn, code, src, dbl, brn, wb, ld, st, base, halt, ill;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  bit   tb_run = 1'b0;
  int   prog_op[128], prog_fn[128];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Instruction-level expectations straight from the decode table and phase list
  function automatic exp_t model(input int op, input int fn);
    exp_t e;
    e = '{default: 0};
    e.op = op; e.fn = fn;
    case (op)
      0: if (fn > 11) begin
           e.halt = 1; e.ill = 1;
         end else begin
           case (fn)
             0: e.code = 1;  1: e.code = 3;  2: e.code = 4;  3: e.code = 5;
             4: e.code = 6;  5: e.code = 7;  6: e.code = 8;  7: e.code = 9;
             8: e.code = 8;  9: e.code = 9;  10: e.code = 10; default: e.code = 10;
           endcase
           e.src  = (fn == 6 || fn == 7 || fn == 10) ? 1 : 0;
           e.dbl  = (fn == 1 || fn == 2) ? 1 : 0;
           e.wb   = 1;
           e.base = 2 + (e.dbl ? 2 : 1) + 1;
         end
      1: begin
           e.code = (fn == 0) ? 5 : (fn == 1) ? 1 : 0;
           e.src = 2; e.wb = 1; e.base = 4;
         end
      2: begin
           e.code = 1; e.src = 2;
           e.ld = (fn == 0) ? 1 : 0; e.st = (fn == 1) ? 1 : 0;
           e.wb = e.ld; e.base = 4 + e.ld;
         end
      3, 5: begin e.brn = 1; e.base = 3; end
      4: begin e.brn = 1; e.wb = (fn % 4 == 0) ? 1 : 0; e.base = 3 + e.wb; end
      6: begin e.halt = 1; e.ill = 1; end
      default: e.halt = 1;
    endcase
    return e;
  endfunction

  function automatic logic [22:0] pack(logic ir, logic pc, logic mr, logic mw, logic rw, logic m2,
                                       logic br, logic [1:0] src, logic [3:0] cd, logic [5:0] bc,
                                       logic dbl, logic bsy, logic hlt, logic ill);
    return {ir, pc, mr, mw, rw, m2, br, src, cd, bc, dbl, bsy, hlt, ill};
  endfunction

  function automatic logic [22:0] obs();
    return pack(ir_load, pc_write, mem_read_en, mem_write_en, reg_write_en, memToReg,
                branch_control, alu_src, code, bcode, double, busy, halted, illegal);
  endfunction

  function automatic logic [15:0] cnt(input int x);
    return PERF ? 16'(x) : 16'd0;
  endfunction

  function automatic logic [63:0] shape(int b, int d, int w, int m, int mw, int s, int r, int br);
    return {28'd0, 8'(b), 4'(d), 4'(w), 4'(m), 4'(mw), 4'(s), 4'(r), 4'(br)};
  endfunction

  // Monitor state
  int   mode = 0, i = 0, waits, dblc, wbc, m2c, m2wc, mwc, mrc, brc;
  int   retired = 0, run_cycles = 0;
  bit   have_cur = 1'b0;
  exp_t cur;

  task automatic open_window();
    mode = 1; i = 0; have_cur = 1'b0;
    waits = 0; dblc = 0; wbc = 0; m2c = 0; m2wc = 0; mwc = 0; mrc = 0; brc = 0;
  endtask

  always @(negedge clk) begin
    logic [5:0] bc;
    if (rst) begin
      check("reset_outputs", {9'd0, obs(), instr_count, cycle_count}, 64'd0);
      mode = 0; q.delete(); retired = 0; run_cycles = 0; have_cur = 1'b0;
    end else begin
      check("invariants", {59'd0, ir_load != pc_write, ir_load & ~(mem_read_en & mem_ready),
                           mem_read_en & mem_write_en, reg_write_en & mem_write_en, busy & halted},
            64'd0);
      bc = 6'(((cur.op & 7) << 3) | (cur.fn & 7));
      case (mode)
        0: begin
          if (!tb_run) begin
            check("idle_outputs", {9'd0, obs(), instr_count, cycle_count}, 64'd0);
          end else begin
            check("fetch_outputs", {41'd0, obs()},
                  {41'd0, pack(mem_ready, mem_ready, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)});
            run_cycles++;
            if (ir_load) open_window();
          end
        end
        1: begin
          i++;
          if (i == 1) begin
            if (q.size() > 0) begin
              cur = q.pop_front(); have_cur = 1'b1;
              bc = 6'(((cur.op & 7) << 3) | (cur.fn & 7));
            end else begin
              n_cmp++; n_bad++;
              $display("FAIL expect_queue: instruction fetched with no expectation queued");
            end
          end
          if (ir_load) begin
            if (have_cur)
              check("instr_shape",
                    shape(i - waits, dblc, wbc, m2c, m2wc, mwc, mrc, brc),
                    shape(cur.base, cur.dbl * 2, cur.wb, cur.ld, cur.ld, cur.st, cur.ld, cur.brn));
            retired++;
            check("counters_retire", {32'd0, instr_count, cycle_count},
                  {32'd0, cnt(retired), cnt(run_cycles)});
            run_cycles++;
            open_window();
          end else if (halted) begin
            check("halt_entry", {32'd0, 8'(i), 8'(halted), 8'(illegal), 8'd0},
                  {32'd0, 8'(cur.halt ? 2 : 255), 8'd1, 8'(cur.ill), 8'd0});
            check("counters_halt", {32'd0, instr_count, cycle_count},
                  {32'd0, cnt(retired), cnt(run_cycles)});
            mode = 2;
          end else begin
            waits += int'((mem_read_en | mem_write_en) & ~mem_ready);
            dblc  += int'(double);
            wbc   += int'(reg_write_en);
            m2c   += int'(memToReg);
            m2wc  += int'(memToReg & reg_write_en);
            mwc   += int'(mem_write_en & mem_ready);
            mrc   += int'(mem_read_en & mem_ready);
            brc   += int'(branch_control);
            if (i == 1)
              check("decode_outputs", {41'd0, obs()},
                    {41'd0, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, bc, 0, 1, 0, 0)});
            if ((i == 2 && cur.halt == 0) || (i == 3 && cur.dbl == 1))
              check("exec_outputs", {41'd0, obs()},
                    {41'd0, pack(0, 0, 0, 0, 0, 0, 1'(cur.brn), 2'(cur.src), 4'(cur.code), bc,
                                 1'(cur.dbl), 1, 0, 0)});
            run_cycles++;
          end
        end
        default: begin
          check("halt_hold", {9'd0, obs(), instr_count, cycle_count},
                {9'd0, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, bc, 0, 0, 1, 1'(cur.ill)),
                 cnt(retired), cnt(run_cycles)});
        end
      endcase
    end
  end

  task automatic do_reset();
    rst = 1'b1; tb_run = 1'b0; mem_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic run_prog(input int n, input int pct, input bit expect_halt);
    int k, budget;
    bit got, seen;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; tb_run = 1'b1;
    k = 0; budget = 0;
    while (k < n && budget < 5000) begin
      opcode = OPW'(prog_op[k]); func = FNW'(prog_fn[k]);
      mem_ready = ($urandom_range(99) < pct);
      @(negedge clk); got = ir_load;
      @(posedge clk); #1;
      if (got) begin
        q.push_back(model(prog_op[k], prog_fn[k]));
        k++;
      end
      budget++;
    end
    check("prog_fetched", k, n);
    if (expect_halt) begin
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        mem_ready = 1'($urandom_range(1));
        @(negedge clk); seen = halted;
        @(posedge clk); #1;
      end
      check("halt_reached", seen, 1);
      repeat (6) begin
        start = 1'($urandom_range(1)); mem_ready = 1'($urandom_range(1));
        opcode = OPW'($urandom_range(7)); func = FNW'($urandom_range(15));
        @(posedge clk); #1;
      end
      start = 1'b0;
      check("queue_drained", q.size(), 0);
    end
  endtask

  task automatic random_prog(input int n);
    for (int j = 0; j < n; j++) begin
      prog_op[j] = $urandom_range(5);
      prog_fn[j] = (prog_op[j] == 0) ? $urandom_range(11) : $urandom_range(15);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; opcode = '0; func = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Directed: every instruction class with memory always ready, ending in HALT
    prog_op[0] = 0; prog_fn[0] = 0;   prog_op[1] = 0; prog_fn[1] = 1;
    prog_op[2] = 2; prog_fn[2] = 0;   prog_op[3] = 2; prog_fn[3] = 1;
    prog_op[4] = 4; prog_fn[4] = 0;   prog_op[5] = 4; prog_fn[5] = 1;
    prog_op[6] = 3; prog_fn[6] = 2;   prog_op[7] = 5; prog_fn[7] = 7;
    prog_op[8] = 1; prog_fn[8] = 0;   prog_op[9] = 1; prog_fn[9] = 1;
    prog_op[10] = 2; prog_fn[10] = 5; prog_op[11] = 0; prog_fn[11] = 10;
    prog_op[12] = 7; prog_fn[12] = 0;
    run_prog(13, 100, 1'b1);
    do_reset();

    random_prog(80); prog_op[80] = 7; prog_fn[80] = $urandom_range(15);
    run_prog(81, 60, 1'b1);
    do_reset();

    random_prog(40); prog_op[40] = 6; prog_fn[40] = $urandom_range(15);
    run_prog(41, 40, 1'b1);
    do_reset();

    random_prog(20); prog_op[20] = 0; prog_fn[20] = 12 + $urandom_range(3);
    run_prog(21, 80, 1'b1);
    do_reset();

    // Reset asserted asynchronously while a load waits in MEM
    prog_op[0] = 0; prog_fn[0] = 3; prog_op[1] = 1; prog_fn[1] = 0;
    prog_op[2] = 2; prog_fn[2] = 0;
    run_prog(3, 100, 1'b0);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mem_read_in_mem", {63'd0, mem_read_en}, 64'd1);
    #2 rst = 1'b1; tb_run = 1'b0;
    #1 check("async_reset", {9'd0, obs(), instr_count, cycle_count}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
